// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port, shared RAM port and status.
// slave = arbiter side; master = requesters plus RAM.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between fetch (i) and load/store (d).
// Define MEM_ARB_RR_EN for round-robin; otherwise d has fixed priority.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          owner_q;
    logic          rvalid_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata_q;

    logic idle;
    logic d_win;
    logic i_gnt;
    logic d_gnt;

    assign idle = rst_n && (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
    // 1 = data port won the last grant; reset points at fetch so d goes first
    logic last_d_q;

    assign d_win = !bus.i_req || !last_d_q;

    // Remember which port won, so the other one wins the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (d_gnt || i_gnt) begin
            last_d_q <= d_gnt;
        end
    end
`else
    assign d_win = 1'b1;
`endif

    assign d_gnt = idle && bus.d_req && d_win;
    assign i_gnt = idle && bus.i_req && !(bus.d_req && d_win);

    // Access sequencer: grant, one-cycle RAM strobe, latency wait, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (d_gnt || i_gnt) begin
                        owner_q    <= d_gnt;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= d_gnt && bus.d_we;
                        mem_addr_q <= d_gnt ? bus.d_addr : bus.i_addr;
                        if (d_gnt) begin
                            mem_wdata_q <= bus.d_wdata;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        rdata_q  <= '0;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else begin
                        cnt_q   <= LAT_C;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    // RAM data is valid LAT cycles after the strobe
                    if (cnt_q == 4'd1) begin
                        rdata_q  <= bus.mem_rdata;
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.i_rvalid  = rvalid_q && !owner_q;
    assign bus.d_rvalid  = rvalid_q && owner_q;
    assign bus.i_rdata   = rdata_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
